// File: rtl/adc_seq_pkg.sv
// Shared types and widths for the ADC conversion sequencer.
package adc_seq_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CH_W   = 3;

  typedef enum logic [2:0] {
    ADC_RST,
    IDLE,
    CONVST,
    WAIT_HI,
    WAIT_LO,
    RD_LO,
    OUT,
    RD_HI
  } state_e;

endpackage

// File: rtl/adc_conv_sequencer_if.sv
// Downstream sample stream (valid/ready) from the ADC sequencer.
// FRAME_CNT_EN adds the sample_frame counter field.
interface adc_conv_sequencer_if;
  import adc_seq_pkg::*;

  logic [DATA_W-1:0] sample_data;
  logic [CH_W-1:0]   sample_ch;
  logic              sample_valid;
  logic              sample_ready;
  logic              frame_done;
`ifdef FRAME_CNT_EN
  logic [15:0]       sample_frame;

  modport master (output sample_data, sample_ch, sample_valid, frame_done, sample_frame,
                  input  sample_ready);
  modport slave  (input  sample_data, sample_ch, sample_valid, frame_done, sample_frame,
                  output sample_ready);
`else
  modport master (output sample_data, sample_ch, sample_valid, frame_done,
                  input  sample_ready);
  modport slave  (input  sample_data, sample_ch, sample_valid, frame_done,
                  output sample_ready);
`endif

endinterface

// File: rtl/adc_sample_timer.sv
// Sample-period divider: counts 0..SAMPLE_DIV-1 while enabled, tick on terminal count.
module adc_sample_timer #(
  parameter int unsigned SAMPLE_DIV = 270
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(SAMPLE_DIV);
  localparam logic [CntW-1:0] Last = CntW'(SAMPLE_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || cnt_q == Last) cnt_d = '0;
    else                            cnt_d = cnt_q + CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = enable_i && (cnt_q == Last);

endmodule

// File: rtl/adc_conv_sequencer.sv
// Periodic conversion/readout sequencer for an 8-channel parallel SAR ADC.
// Optional FRAME_CNT_EN adds a 16-bit frame counter on the sample stream.
module adc_conv_sequencer
  import adc_seq_pkg::*;
#(
  parameter int unsigned SAMPLE_DIV  = 270,
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CONVST_CYC  = 2,
  parameter int unsigned RD_LOW_CYC  = 3,
  parameter int unsigned RD_HIGH_CYC = 2,
  parameter int unsigned RST_CYC     = 8,
  parameter int unsigned BUSY_TO     = 200
) (
  input  logic                 CLOCK_27M,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 Busy,
  input  logic [DATA_W-1:0]    DB,
  output logic                 convst_A,
  output logic                 convst_B,
  output logic                 convst_C,
  output logic                 convst_D,
  output logic                 RD_N,
  output logic                 ADC_CS_N,
  output logic                 ADCrst,
  output logic                 STBY_N,
  output logic                 HW_N,
  output logic                 PAR_N,
  output logic                 WR_N,
  adc_conv_sequencer_if.master smp,
  output logic                 overrun,
  output logic                 busy_err
);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [CH_W-1:0]   ch_q, ch_d, sch_q, sch_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              ovr_q, ovr_d, err_q, err_d;
  logic              busy_meta_q, busy_sync_q;
  logic              tick;

  adc_sample_timer #(
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_timer (
    .clk_i    (CLOCK_27M),
    .rst_ni   (rst),
    .enable_i (enable),
    .tick_o   (tick)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    ch_d    = ch_q;
    sch_d   = sch_q;
    data_d  = data_q;
    done_d  = 1'b0;
    // Ticks outside IDLE are dropped and flagged; the running frame is unaffected.
    ovr_d   = ovr_q | (tick && state_q != IDLE);
    err_d   = err_q;
    unique case (state_q)
      ADC_RST: if (cnt_q == 16'(RST_CYC - 1)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      IDLE: begin
        cnt_d = '0;
        if (tick) state_d = CONVST;
      end
      CONVST: if (cnt_q == 16'(CONVST_CYC - 1)) begin
        state_d = WAIT_HI;
        cnt_d   = '0;
      end
      WAIT_HI: begin
        if (busy_sync_q) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end else if (cnt_q == 16'(BUSY_TO - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      WAIT_LO: begin
        if (!busy_sync_q) begin
          state_d = RD_LO;
          ch_d    = '0;
          cnt_d   = '0;
        end else if (cnt_q == 16'(BUSY_TO - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      RD_LO: if (cnt_q == 16'(RD_LOW_CYC - 1)) begin
        data_d  = DB;
        sch_d   = ch_q;
        state_d = OUT;
        cnt_d   = '0;
      end
      OUT: begin
        cnt_d = '0;
        if (smp.sample_ready) begin
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            ch_d    = ch_q + CH_W'(1);
            state_d = RD_HI;
          end
        end
      end
      RD_HI: if (cnt_q == 16'(RD_HIGH_CYC - 1)) begin
        state_d = RD_LO;
        cnt_d   = '0;
      end
      default: state_d = ADC_RST;
    endcase
  end

  always_ff @(posedge CLOCK_27M or negedge rst) begin
    if (!rst) begin
      state_q     <= ADC_RST;
      cnt_q       <= '0;
      ch_q        <= '0;
      sch_q       <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_meta_q <= 1'b0;
      busy_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      sch_q       <= sch_d;
      data_q      <= data_d;
      done_q      <= done_d;
      ovr_q       <= ovr_d;
      err_q       <= err_d;
      busy_meta_q <= Busy;
      busy_sync_q <= busy_meta_q;
    end
  end

`ifdef FRAME_CNT_EN
  logic [15:0] frame_q;

  always_ff @(posedge CLOCK_27M or negedge rst) begin
    if (!rst)        frame_q <= '0;
    else if (done_d) frame_q <= frame_q + 16'd1;
  end

  assign smp.sample_frame = frame_q;
`endif

  assign convst_A = (state_q == CONVST);
  assign convst_B = convst_A;
  assign convst_C = convst_A;
  assign convst_D = convst_A;
  assign RD_N     = (state_q != RD_LO);
  assign ADC_CS_N = (state_q != RD_LO);
  assign ADCrst   = (state_q == ADC_RST);
  assign STBY_N   = 1'b1;
  assign HW_N     = 1'b0;
  assign PAR_N    = 1'b0;
  assign WR_N     = 1'b1;

  assign smp.sample_data  = data_q;
  assign smp.sample_ch    = sch_q;
  assign smp.sample_valid = (state_q == OUT);
  assign smp.frame_done   = done_q;
  assign overrun          = ovr_q;
  assign busy_err         = err_q;

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// Directed bench for adc_conv_sequencer with a simple BUSY/DB ADC model.
module tb_adc_conv_sequencer;
  import adc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, enable, Busy;
  logic [15:0] DB;
  logic        convst_A, convst_B, convst_C, convst_D;
  logic        RD_N, ADC_CS_N, ADCrst, STBY_N, HW_N, PAR_N, WR_N;
  logic        overrun, busy_err;
  logic        bfm_mute;

  adc_conv_sequencer_if sif ();

  adc_conv_sequencer dut (
    .CLOCK_27M (clk),
    .rst       (rst),
    .enable    (enable),
    .Busy      (Busy),
    .DB        (DB),
    .convst_A  (convst_A),
    .convst_B  (convst_B),
    .convst_C  (convst_C),
    .convst_D  (convst_D),
    .RD_N      (RD_N),
    .ADC_CS_N  (ADC_CS_N),
    .ADCrst    (ADCrst),
    .STBY_N    (STBY_N),
    .HW_N      (HW_N),
    .PAR_N     (PAR_N),
    .WR_N      (WR_N),
    .smp       (sif),
    .overrun   (overrun),
    .busy_err  (busy_err)
  );

  always #5 clk = ~clk;

  int cyc;
  int fd_last, fd_prev, conv_cyc;
  logic [7:0] bcnt;
  logic [2:0] rd_idx;
  logic       conv_prev, rd_prev;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: BUSY high for 40 cycles starting ~3 cycles after CONVST; DB = 0x1000 + read index.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt <= '0; Busy <= 1'b0; conv_prev <= 1'b0; rd_prev <= 1'b1; rd_idx <= '0;
    end else begin
      conv_prev <= convst_A;
      rd_prev   <= RD_N;
      if (convst_A && !conv_prev) begin
        bcnt     <= 8'd1;
        conv_cyc <= cyc;
      end else if (bcnt != 0) bcnt <= (bcnt == 8'd43) ? 8'd0 : bcnt + 8'd1;
      Busy <= !bfm_mute && bcnt >= 8'd3 && bcnt < 8'd43;
      if (convst_A)            rd_idx <= '0;
      else if (RD_N && !rd_prev) rd_idx <= rd_idx + 3'd1;
    end
  end
  assign DB = 16'h1000 + {13'd0, rd_idx};

  always @(posedge clk) begin
    if (sif.frame_done) begin
      fd_prev <= fd_last;
      fd_last <= cyc;
    end
  end

  int n_pass = 0;
  int n_checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic adcrst_width(input string name);
    int ones = 0;
    for (int i = 0; i < 20; i++) begin
      if (ADCrst) ones++;
      @(negedge clk);
    end
    check(name, ones, 8);
  endtask

  task automatic get_word(input string tag, input logic [15:0] ed, input logic [2:0] ec,
                          input int stall, input bit last);
    bit ok = 0;
    bit stable = 1;
    for (int i = 0; i < 600; i++) begin
      if (sif.sample_valid) begin ok = 1; break; end
      @(negedge clk);
    end
    check({tag, " valid arrives"}, ok, 1);
    if (!ok) return;
    check({tag, " data"}, sif.sample_data, ed);
    check({tag, " ch"}, sif.sample_ch, ec);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (sif.sample_data !== ed || sif.sample_ch !== ec || !sif.sample_valid || !RD_N)
          stable = 0;
      end
      check({tag, " held stable"}, stable, 1);
    end
    sif.sample_ready = 1'b1;
    @(negedge clk);
    sif.sample_ready = 1'b0;
    check({tag, " valid drops"}, sif.sample_valid, 0);
    check({tag, " frame_done"}, sif.frame_done, last);
    if (last) begin
      @(negedge clk);
      check({tag, " frame_done one cycle"}, sif.frame_done, 0);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic [2:0]  ch;
    int          stall;
  } vec_t;

  vec_t vecs[24];

  initial begin
    int convs;
    int err_cyc;
    bit err_seen, valid_seen, rd_found;

    for (int f = 0; f < 3; f++)
      for (int c = 0; c < 8; c++)
        vecs[f*8+c] = '{data: 16'h1000 + 16'(c), ch: 3'(c), stall: (f == 2 && c == 3) ? 20 : 0};

    rst = 1'b0; enable = 1'b0; bfm_mute = 1'b0; sif.sample_ready = 1'b0;
    #1;
    check("rst convst_A", convst_A, 0);
    check("rst convst_D", convst_D, 0);
    check("rst RD_N", RD_N, 1);
    check("rst ADC_CS_N", ADC_CS_N, 1);
    check("rst ADCrst", ADCrst, 1);
    check("rst sample_valid", sif.sample_valid, 0);
    check("rst sample_data", sif.sample_data, 0);
    check("rst sample_ch", sif.sample_ch, 0);
    check("rst frame_done", sif.frame_done, 0);
    check("rst overrun", overrun, 0);
    check("rst busy_err", busy_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    adcrst_width("ADCrst width after reset");
    check("STBY_N", STBY_N, 1);
    check("HW_N", HW_N, 0);
    check("PAR_N", PAR_N, 0);
    check("WR_N", WR_N, 1);

    convs = 0;
    repeat (1000) begin
      @(negedge clk);
      if (convst_A | convst_B | convst_C | convst_D) convs++;
    end
    check("no convst while disabled", convs, 0);

    enable = 1'b1;
    for (int i = 0; i < 24; i++) begin
      get_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].ch, vecs[i].stall, vecs[i].ch == 3'd7);
      if (i == 15) check("frame period", fd_last - fd_prev, 270);
    end
    check("no overrun after short stall", overrun, 0);

    // Long stall on ch0 spans ticks: overrun sets, frame still completes.
    get_word("long stall ch0", 16'h1000, 3'd0, 400, 1'b0);
    check("overrun after long stall", overrun, 1);
    for (int c = 1; c < 8; c++)
      get_word($sformatf("long stall ch%0d", c), 16'h1000 + 16'(c), 3'(c), 0, c == 7);
    for (int c = 0; c < 8; c++)
      get_word($sformatf("post stall ch%0d", c), 16'h1000 + 16'(c), 3'(c), 0, c == 7);
    check("overrun sticky", overrun, 1);

    // BUSY never rises: timeout, no data, back to idle, then a normal frame.
    bfm_mute = 1'b1;
    err_seen = 0; valid_seen = 0; err_cyc = 0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clk);
      if (sif.sample_valid) valid_seen = 1;
      if (busy_err) begin err_seen = 1; err_cyc = cyc; break; end
    end
    check("busy_err set", err_seen, 1);
    check("busy timeout latency", (err_cyc - conv_cyc >= 190) && (err_cyc - conv_cyc <= 215), 1);
    check("no valid on timeout", valid_seen, 0);
    @(negedge clk);
    check("idle after timeout RD_N", RD_N, 1);
    check("idle after timeout convst", convst_A, 0);
    bfm_mute = 1'b0;
    for (int c = 0; c < 8; c++)
      get_word($sformatf("recover ch%0d", c), 16'h1000 + 16'(c), 3'(c), 0, c == 7);
    check("busy_err sticky", busy_err, 1);

    // Reset in the middle of the ch5 read.
    for (int c = 0; c < 5; c++)
      get_word($sformatf("pre-reset ch%0d", c), 16'h1000 + 16'(c), 3'(c), 0, 1'b0);
    rd_found = 0;
    for (int i = 0; i < 30; i++) begin
      if (!RD_N) begin rd_found = 1; break; end
      @(negedge clk);
    end
    check("ch5 read starts", rd_found, 1);
    rst = 1'b0;
    #1;
    check("mid-read rst RD_N", RD_N, 1);
    check("mid-read rst ADC_CS_N", ADC_CS_N, 1);
    check("mid-read rst sample_valid", sif.sample_valid, 0);
    check("mid-read rst ADCrst", ADCrst, 1);
    check("mid-read rst overrun", overrun, 0);
    check("mid-read rst busy_err", busy_err, 0);
    @(negedge clk);
    rst = 1'b1;
    adcrst_width("ADCrst width after second reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
